rv2t_stage_sequencer: RTL and testbench

RV2T_STAGE_SEQUENCER -- requirements
Module: rv2t_stage_sequencer

---
 rtl/rv2t_ctl_pkg.sv | 39 +++
 rtl/rv2t_mem_timeout.sv | 41 ++++
 rtl/rv2t_stage_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_rv2t_stage_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv2t_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv2t_ctl_pkg
// Description : Shared control definitions for the RV2T stage sequencer:
//               FSM state encodings, trap cause codes and a helper that sizes
//               the MEM_WAIT timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
package rv2t_ctl_pkg;

  // Sequencer states; the numeric values are visible on the debug port
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FETCH       = 3'd1,
    ST_DECODE      = 3'd2,
    ST_EXECUTE     = 3'd3,
    ST_MEM_WAIT    = 3'd4,
    ST_MULDIV_WAIT = 3'd5,
    ST_WRITEBACK   = 3'd6,
    ST_SLEEP       = 3'd7
  } rv2t_state_e;

  // Trap cause codes (RISC-V mcause numbering)
  localparam logic [3:0] c_CAUSE_NONE        = 4'd0;
  localparam logic [3:0] c_CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] c_CAUSE_LOAD_FAULT  = 4'd5;
  localparam logic [3:0] c_CAUSE_STORE_FAULT = 4'd7;
  localparam logic [3:0] c_CAUSE_M_IRQ       = 4'd11;

  // Counter width able to hold the value max_count (never narrower than 1)
  function automatic int timeout_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv2t_mem_timeout.sv
`default_nettype none
// ============================================================================
// Module      : rv2t_mem_timeout
// Description : Saturating cycle counter for the MEM_WAIT state. Counts up
//               from zero while enabled and flags when MAX_COUNT is reached.
//               A synchronous clear takes priority over counting.
// Revision    : 1.0 - initial release
// ============================================================================
module rv2t_mem_timeout
  import rv2t_ctl_pkg::*;
#(
  parameter int MAX_COUNT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                 CNT_W   = timeout_width(MAX_COUNT);
  localparam logic [CNT_W-1:0]   c_LIMIT = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0]   c_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Count cycles while enabled; hold at the limit so expired stays asserted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign expired = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/rv2t_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rv2t_stage_sequencer
// Description : Multi-cycle pipeline stage sequencer for the RV2T core.
//               Walks each instruction through FETCH, DECODE, EXECUTE, an
//               optional wait state (memory, mul/div or WFI sleep) and
//               WRITEBACK, producing one-cycle stage strobes and the trap
//               entry strobe with its cause code.
//               Optional feature macro: RV2T_HW_MUL_DIV_EN
//                 defined   - mul/div ops wait in MULDIV_WAIT for muldiv_done
//                 undefined - mul/div ops trap as illegal instructions
// Revision    : 1.0 - initial release
// ============================================================================
module rv2t_stage_sequencer
  import rv2t_ctl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sync_reset,
  input  logic       run,
  input  logic       fetch_done,
  input  logic       ctl_LOAD,
  input  logic       ctl_STORE,
  input  logic       ctl_MUL_DIV_FUNCT3,
  input  logic       ctl_WFI,
  input  logic       ctl_MRET,
  input  logic       illegal_instr,
  input  logic       mem_done,
  input  logic       muldiv_done,
  input  logic       irq_pending,
  output logic       fetch_enable,
  output logic       decode_enable,
  output logic       exe_enable,
  output logic       mem_enable,
  output logic       wb_enable,
  output logic       trap_enable,
  output logic [3:0] trap_cause,
  output logic [2:0] state
);

  rv2t_state_e r_state;
  rv2t_state_e w_next_state;

  logic       r_fetch_enable;
  logic       r_decode_enable;
  logic       r_exe_enable;
  logic       r_mem_enable;
  logic       r_wb_enable;
  logic       r_trap_enable;
  logic [3:0] r_trap_cause;

  // Remembers whether the access now in MEM_WAIT is a store (fault cause 7)
  logic       r_is_store;

  // Exception detected on the transition into WRITEBACK
  logic       w_wb_exc;
  logic [3:0] w_wb_cause;
  logic       w_enter_wb;

  logic       w_cnt_clear;
  logic       w_cnt_enable;
  logic       w_mem_expired;

  // MRET needs no sequencing beyond the plain path; mul/div completion is
  // only meaningful when the hardware unit is present
`ifdef RV2T_HW_MUL_DIV_EN
  logic w_unused_inputs;
  assign w_unused_inputs = ctl_MRET;
`else
  logic w_unused_inputs;
  assign w_unused_inputs = ctl_MRET ^ muldiv_done;
`endif

  // The timeout counter runs only inside MEM_WAIT and restarts from zero on
  // every entry because it is held clear in all other states
  assign w_cnt_enable = (r_state == ST_MEM_WAIT);
  assign w_cnt_clear  = sync_reset || (r_state != ST_MEM_WAIT);

  rv2t_mem_timeout #(
    .MAX_COUNT (MEM_TIMEOUT)
  ) u_mem_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_cnt_clear),
    .enable  (w_cnt_enable),
    .expired (w_mem_expired)
  );

  // Next-state selection and exception detection for the WRITEBACK entry
  always_comb begin
    w_next_state = r_state;
    w_wb_exc     = 1'b0;
    w_wb_cause   = c_CAUSE_NONE;
    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fetch_done) begin
          w_next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_next_state = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (illegal_instr) begin
          w_next_state = ST_WRITEBACK;
          w_wb_exc     = 1'b1;
          w_wb_cause   = c_CAUSE_ILLEGAL;
        end else if (ctl_LOAD || ctl_STORE) begin
          w_next_state = ST_MEM_WAIT;
        end else if (ctl_MUL_DIV_FUNCT3) begin
`ifdef RV2T_HW_MUL_DIV_EN
          w_next_state = ST_MULDIV_WAIT;
`else
          w_next_state = ST_WRITEBACK;
          w_wb_exc     = 1'b1;
          w_wb_cause   = c_CAUSE_ILLEGAL;
`endif
        end else if (ctl_WFI) begin
          w_next_state = ST_SLEEP;
        end else begin
          w_next_state = ST_WRITEBACK;
        end
      end
      ST_MEM_WAIT: begin
        // A completion arriving on the timeout cycle is not a fault
        if (mem_done) begin
          w_next_state = ST_WRITEBACK;
        end else if (w_mem_expired) begin
          w_next_state = ST_WRITEBACK;
          w_wb_exc     = 1'b1;
          w_wb_cause   = r_is_store ? c_CAUSE_STORE_FAULT : c_CAUSE_LOAD_FAULT;
        end
      end
      ST_MULDIV_WAIT: begin
`ifdef RV2T_HW_MUL_DIV_EN
        if (muldiv_done) begin
          w_next_state = ST_WRITEBACK;
        end
`else
        w_next_state = ST_IDLE;
`endif
      end
      ST_SLEEP: begin
        if (irq_pending) begin
          w_next_state = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        w_next_state = run ? ST_FETCH : ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_enter_wb = (w_next_state == ST_WRITEBACK);

  // State register with registered stage strobes; each strobe is raised on
  // the edge that enters its state, so it covers that state's first cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_fetch_enable  <= 1'b0;
      r_decode_enable <= 1'b0;
      r_exe_enable    <= 1'b0;
      r_mem_enable    <= 1'b0;
      r_wb_enable     <= 1'b0;
      r_trap_enable   <= 1'b0;
      r_trap_cause    <= c_CAUSE_NONE;
      r_is_store      <= 1'b0;
    end else if (sync_reset) begin
      r_state         <= ST_IDLE;
      r_fetch_enable  <= 1'b0;
      r_decode_enable <= 1'b0;
      r_exe_enable    <= 1'b0;
      r_mem_enable    <= 1'b0;
      r_wb_enable     <= 1'b0;
      r_trap_enable   <= 1'b0;
      r_is_store      <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_fetch_enable  <= (w_next_state == ST_FETCH)    && (r_state != ST_FETCH);
      r_decode_enable <= (w_next_state == ST_DECODE)   && (r_state != ST_DECODE);
      r_exe_enable    <= (w_next_state == ST_EXECUTE)  && (r_state != ST_EXECUTE);
      r_mem_enable    <= (w_next_state == ST_MEM_WAIT) && (r_state != ST_MEM_WAIT);

      // Exceptions suppress the register write and win over interrupts
      r_wb_enable     <= w_enter_wb && !w_wb_exc;
      r_trap_enable   <= w_enter_wb && (w_wb_exc || irq_pending);
      if (w_enter_wb && w_wb_exc) begin
        r_trap_cause <= w_wb_cause;
      end else if (w_enter_wb && irq_pending) begin
        r_trap_cause <= c_CAUSE_M_IRQ;
      end

      // Decode strobes may drop once EXECUTE is over, so capture the
      // access direction here; a load wins if both are flagged
      if (r_state == ST_EXECUTE) begin
        r_is_store <= ctl_STORE && !ctl_LOAD;
      end
    end
  end

  assign fetch_enable  = r_fetch_enable;
  assign decode_enable = r_decode_enable;
  assign exe_enable    = r_exe_enable;
  assign mem_enable    = r_mem_enable;
  assign wb_enable     = r_wb_enable;
  assign trap_enable   = r_trap_enable;
  assign trap_cause    = r_trap_cause;
  assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rv2t_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv2t_stage_sequencer
// Description : Self-checking bench for rv2t_stage_sequencer. A table of
//               instruction records (decode strobes, completion timing and
//               expected WRITEBACK outcome) is replayed through the FSM, then
//               hand-written sequences cover asynchronous reset inside
//               MEM_WAIT and synchronous reset inside SLEEP.
//               Honours RV2T_HW_MUL_DIV_EN for the mul/div expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rv2t_stage_sequencer;

  localparam int MEM_TO = 4;

  logic       clk = 1'b0;
  logic       reset_n, sync_reset, run, fetch_done;
  logic       ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_WFI, ctl_MRET;
  logic       illegal_instr, mem_done, muldiv_done, irq_pending;
  logic       fetch_enable, decode_enable, exe_enable, mem_enable, wb_enable, trap_enable;
  logic [3:0] trap_cause;
  logic [2:0] state;

  rv2t_stage_sequencer #(
    .MEM_TIMEOUT (MEM_TO)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .sync_reset         (sync_reset),
    .run                (run),
    .fetch_done         (fetch_done),
    .ctl_LOAD           (ctl_LOAD),
    .ctl_STORE          (ctl_STORE),
    .ctl_MUL_DIV_FUNCT3 (ctl_MUL_DIV_FUNCT3),
    .ctl_WFI            (ctl_WFI),
    .ctl_MRET           (ctl_MRET),
    .illegal_instr      (illegal_instr),
    .mem_done           (mem_done),
    .muldiv_done        (muldiv_done),
    .irq_pending        (irq_pending),
    .fetch_enable       (fetch_enable),
    .decode_enable      (decode_enable),
    .exe_enable         (exe_enable),
    .mem_enable         (mem_enable),
    .wb_enable          (wb_enable),
    .trap_enable        (trap_enable),
    .trap_cause         (trap_cause),
    .state              (state)
  );

  always #5 clk = ~clk;

  // One instruction: decode strobes, cycle index of the completion event in
  // the wait state (-1 = never), and the expected WRITEBACK outcome
  typedef struct {
    string      name;
    bit         ld, st, md, wfi, mret, ill, irq, run_after;
    int         d;
    int         exp_wait;
    bit         exp_wb, exp_trap;
    logic [3:0] cause;
  } vec_t;

  vec_t       vecs [12];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cause_hold;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic clear_ctl;
    ctl_LOAD = 0; ctl_STORE = 0; ctl_MUL_DIV_FUNCT3 = 0;
    ctl_WFI = 0; ctl_MRET = 0; illegal_instr = 0;
  endtask

  // Fetch (fetch_done two cycles after entry), decode, and stop in EXECUTE
  task automatic to_execute(input vec_t v);
    if (state != 3'd1) begin
      run = 1;
      tick;
    end
    chk({v.name, " fetch_state"}, state, 1);
    chk({v.name, " fetch_en"}, fetch_enable, 1);
    tick;
    tick;
    chk({v.name, " fetch_hold"}, state, 1);
    chk({v.name, " fetch_en_once"}, fetch_enable, 0);
    fetch_done = 1;
    tick;
    fetch_done = 0;
    chk({v.name, " decode_state"}, state, 2);
    chk({v.name, " decode_en"}, decode_enable, 1);
    ctl_LOAD = v.ld; ctl_STORE = v.st; ctl_MUL_DIV_FUNCT3 = v.md;
    ctl_WFI = v.wfi; ctl_MRET = v.mret; illegal_instr = v.ill;
    irq_pending = v.irq;
    if (!v.run_after) run = 0;
    tick;
    chk({v.name, " exe_state"}, state, 3);
    chk({v.name, " exe_en"}, exe_enable, 1);
    chk({v.name, " decode_once"}, decode_enable, 0);
  endtask

  task automatic run_instr(input vec_t v);
    int n;
    to_execute(v);
    tick;
    clear_ctl;
    n = 0;
    while (state != 3'd6 && n < 200) begin
      if (state == 3'd4 && n == 0) chk({v.name, " mem_en"}, mem_enable, 1);
      if (state == 3'd4 && n == 1) chk({v.name, " mem_en_once"}, mem_enable, 0);
      mem_done    = (state == 3'd4) && (n == v.d);
      muldiv_done = (state == 3'd5) && (n == v.d);
      irq_pending = v.irq || ((state == 3'd7) && (n == v.d));
      tick;
      n++;
    end
    chk({v.name, " wait_cycles"}, n, v.exp_wait);
    chk({v.name, " wb_state"}, state, 6);
    if (v.exp_trap) exp_cause_hold = v.cause;
    chk({v.name, " wb_enable"}, wb_enable, v.exp_wb);
    chk({v.name, " trap_enable"}, trap_enable, v.exp_trap);
    chk({v.name, " trap_cause"}, trap_cause, exp_cause_hold);
    mem_done = 0; muldiv_done = 0; irq_pending = 0;
    tick;
    chk({v.name, " post_state"}, state, v.run_after ? 1 : 0);
    chk({v.name, " wb_once"}, wb_enable, 0);
    chk({v.name, " trap_once"}, trap_enable, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t t;
    //            name          ld st md wf mr il iq ra  d   wait wb tr cause
    vecs[0]  = '{"alu",         0, 0, 0, 0, 0, 0, 0, 1, -1,  0,   1, 0, 4'd0};
    vecs[1]  = '{"alu_irq",     0, 0, 0, 0, 0, 0, 1, 1, -1,  0,   1, 1, 4'd11};
    vecs[2]  = '{"load_done2",  1, 0, 0, 0, 0, 0, 0, 1,  2,  3,   1, 0, 4'd0};
    vecs[3]  = '{"load_tmo",    1, 0, 0, 0, 0, 0, 0, 1, -1,  5,   0, 1, 4'd5};
    vecs[4]  = '{"store_coinc", 0, 1, 0, 0, 0, 0, 0, 1,  4,  5,   1, 0, 4'd0};
    vecs[5]  = '{"store_tmo",   0, 1, 0, 0, 0, 0, 0, 1, -1,  5,   0, 1, 4'd7};
    vecs[6]  = '{"ill_load",    1, 0, 0, 0, 0, 1, 0, 1, -1,  0,   0, 1, 4'd2};
    vecs[7]  = '{"ill_irq",     0, 0, 0, 0, 0, 1, 1, 1, -1,  0,   0, 1, 4'd2};
    vecs[8]  = '{"wfi",         0, 0, 0, 1, 0, 0, 0, 1, 10, 11,   1, 1, 4'd11};
`ifdef RV2T_HW_MUL_DIV_EN
    vecs[9]  = '{"muldiv",      0, 0, 1, 0, 0, 0, 0, 1, 32, 33,   1, 0, 4'd0};
`else
    vecs[9]  = '{"muldiv",      0, 0, 1, 0, 0, 0, 0, 1, 32,  0,   0, 1, 4'd2};
`endif
    vecs[10] = '{"mret_stop",   0, 0, 0, 0, 1, 0, 0, 0, -1,  0,   1, 0, 4'd0};
    vecs[11] = '{"store_done0", 0, 1, 0, 0, 0, 0, 0, 1,  0,  1,   1, 0, 4'd0};

    reset_n = 0; sync_reset = 0; run = 0; fetch_done = 0;
    mem_done = 0; muldiv_done = 0; irq_pending = 0;
    clear_ctl;
    exp_cause_hold = 4'd0;
    tick;
    tick;
    chk("reset state", state, 0);
    chk("reset strobes", {fetch_enable, decode_enable, exe_enable, mem_enable, wb_enable, trap_enable}, 0);
    chk("reset cause", trap_cause, 0);
    reset_n = 1;
    tick;
    chk("idle without run", state, 0);

    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i]);
    end

    // Asynchronous reset in the middle of MEM_WAIT
    t = vecs[3];
    t.name = "areset";
    to_execute(t);
    tick;
    clear_ctl;
    chk("areset in mem_wait", state, 4);
    tick;
    tick;
    reset_n = 0;
    #1;
    chk("areset immediate state", state, 0);
    chk("areset immediate cause", trap_cause, 0);
    exp_cause_hold = 4'd0;
    tick;
    run = 0;
    reset_n = 1;
    tick;
    chk("areset no strobes", {wb_enable, trap_enable, fetch_enable}, 0);
    chk("areset stays idle", state, 0);
    // A fresh timeout must take the full count again
    run_instr(vecs[3]);

    // Synchronous reset while sleeping overrides a pending interrupt and run
    t = vecs[8];
    t.name = "sreset";
    to_execute(t);
    tick;
    clear_ctl;
    chk("sreset in sleep", state, 7);
    tick;
    tick;
    sync_reset = 1;
    irq_pending = 1;
    tick;
    chk("sreset state", state, 0);
    chk("sreset strobes", {fetch_enable, decode_enable, exe_enable, mem_enable, wb_enable, trap_enable}, 0);
    sync_reset = 0;
    irq_pending = 0;
    run = 0;
    tick;
    chk("sreset stays idle", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
